// File: rtl/sine_approx_pkg.sv
// Shared constants and bundle types for the sine lookup path.
// SINE_INTERP_EN widens the phase word and adds the interpolation stage.
`ifndef SINE_WORDS
`define SINE_WORDS 4096
`endif
`ifndef QTR_WORDS
`define QTR_WORDS 1024
`endif

package sine_approx_pkg;
  localparam int ANGLE_W    = 12;
  localparam int OUT_W      = 16;
  localparam int FRAC_W     = 4;
  localparam int SINE_WORDS = `SINE_WORDS;
  localparam int QTR_WORDS  = `QTR_WORDS;
  localparam int IDX_W      = ANGLE_W - 1;
  localparam int MAG_W      = OUT_W - 1;
`ifdef SINE_INTERP_EN
  localparam int PHASE_W      = ANGLE_W + FRAC_W;
  localparam int SINE_LATENCY = 4;
`else
  localparam int PHASE_W      = ANGLE_W;
  localparam int SINE_LATENCY = 3;
`endif

  typedef logic [PHASE_W-1:0]     pac2sine_approx_t;
  typedef logic signed [OUT_W-1:0] sine2out_t;
  typedef logic [IDX_W-1:0]       qidx_t;
  typedef logic [MAG_W-1:0]       qmag_t;
endpackage

// File: rtl/sine_qrom.sv
// Quarter-wave magnitude table, 1025 entries, registered read.
// Second read port exists only with SINE_INTERP_EN.
module sine_qrom
  import sine_approx_pkg::*;
(
  input  logic  clk,
  input  logic  en,
  input  qidx_t addr_a,
  output qmag_t data_a
`ifdef SINE_INTERP_EN
  ,
  input  qidx_t addr_b,
  output qmag_t data_b
`endif
);
  localparam real PI = 3.14159265358979323846;
  localparam real FS = real'((2 ** MAG_W) - 1);

  qmag_t tbl [QTR_WORDS+1];

  // Contents are folded at elaboration: round(FS*sin(pi*k/(2*QTR)))
  for (genvar g = 0; g <= QTR_WORDS; g++) begin : g_tbl
    localparam real PH = PI * g / (2.0 * QTR_WORDS);
    assign tbl[g] = qmag_t'($rtoi(FS * $sin(PH) + 0.5));
  end

  always_ff @(posedge clk) begin
    if (en) begin
      data_a <= tbl[addr_a];
`ifdef SINE_INTERP_EN
      data_b <= tbl[addr_b];
`endif
    end
  end
endmodule

// File: rtl/sine_approx.sv
// Phase word -> signed sine sample via quarter-wave folding, 3-stage pipe.
// SINE_INTERP_EN adds linear interpolation on FRAC_W bits (latency 4).
module sine_approx
  import sine_approx_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  pac2sine_approx_t angle,
  input  logic             angle_valid,
  output sine2out_t        sample,
  output logic             sample_valid
);
  logic [1:0]         q;
  logic [ANGLE_W-3:0] i;
  qidx_t              ka_d;

  assign q = angle[PHASE_W-1 -: 2];
  assign i = angle[PHASE_W-3 -: ANGLE_W-2];

  always_comb begin
    ka_d = qidx_t'(i);
    if (q[0]) ka_d = qidx_t'(QTR_WORDS) - qidx_t'(i);
  end

  logic  v1, neg1, v2, neg2;
  qidx_t ka1;
  qmag_t mag_a, mag_o;
  logic  neg_o, v_o;

`ifdef SINE_INTERP_EN
  localparam int IW = OUT_W + FRAC_W + 1;
  logic [FRAC_W-1:0] f1, f2;
  qidx_t             kb_d, kb1;
  qmag_t             mag_b, mag3;
  logic              v3, neg3;
  logic signed [IW-1:0] a_s, b_s, f_s, prod, v_s;

  // Second tap follows the phase direction: away from k in rising
  // quadrants, toward zero in falling ones, so it never leaves 0..QTR.
  assign kb_d = q[0] ? ka_d - qidx_t'(1) : ka_d + qidx_t'(1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      neg1 <= 1'b0;
      ka1  <= '0;
`ifdef SINE_INTERP_EN
      kb1  <= '0;
      f1   <= '0;
`endif
    end else begin
      v1 <= angle_valid;
      if (angle_valid) begin
        neg1 <= q[1];
        ka1  <= ka_d;
`ifdef SINE_INTERP_EN
        kb1  <= kb_d;
        f1   <= angle[FRAC_W-1:0];
`endif
      end
    end
  end

  sine_qrom u_rom (
    .clk    (clk),
    .en     (v1),
    .addr_a (ka1),
    .data_a (mag_a)
`ifdef SINE_INTERP_EN
    ,
    .addr_b (kb1),
    .data_b (mag_b)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      neg2 <= 1'b0;
`ifdef SINE_INTERP_EN
      f2   <= '0;
`endif
    end else begin
      v2 <= v1;
      if (v1) begin
        neg2 <= neg1;
`ifdef SINE_INTERP_EN
        f2   <= f1;
`endif
      end
    end
  end

`ifdef SINE_INTERP_EN
  assign a_s  = IW'(mag_a);
  assign b_s  = IW'(mag_b);
  assign f_s  = IW'(f2);
  assign prod = (b_s - a_s) * f_s;
  assign v_s  = a_s + (prod >>> FRAC_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3   <= 1'b0;
      neg3 <= 1'b0;
      mag3 <= '0;
    end else begin
      v3 <= v2;
      if (v2) begin
        neg3 <= neg2;
        mag3 <= qmag_t'(v_s);
      end
    end
  end

  assign mag_o = mag3;
  assign neg_o = neg3;
  assign v_o   = v3;
`else
  assign mag_o = mag_a;
  assign neg_o = neg2;
  assign v_o   = v2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= v_o;
      if (v_o)
        sample <= neg_o ? -sine2out_t'(mag_o) : sine2out_t'(mag_o);
    end
  end
endmodule

// File: doc/sine_approx.md
Name: sine_approx

Overview:
- Downstream neighbour of the phase accumulator. Converts each accumulated phase word into a signed sine sample.
- Uses a quarter-wave ROM with quadrant folding and sign restoration, in a fully pipelined 3-stage datapath with a valid strobe.
- Output feeds the oscillator mixer / DAC path. Accepts one new phase word per clk.

Parameters:
- ANGLE_W, 12, phase width. Full cycle = `SINE_WORDS = 2^ANGLE_W = 4096 words.
- OUT_W, 16, signed sample width. Full scale = 2^(OUT_W-1)-1 = 32767.
- FRAC_W, 4, extra fractional phase bits. Used only when SINE_INTERP_EN is defined.
- ROM_FILE, "sine_qtr.hex", init file for the quarter ROM.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- angle  in  `pac2sine_approx_t (ANGLE_W, or ANGLE_W+FRAC_W with SINE_INTERP_EN)  phase word from the PAC.
- angle_valid  in  1  one-cycle strobe, high on the PAC tick when angle is new.
- sample  out  OUT_W signed  sine sample.
- sample_valid  out  1  one-cycle strobe, high when sample is updated.

Behaviour:
- Reset: asynchronous assert, synchronous-safe release. All pipeline valid bits, sample and sample_valid = 0. Reset mid-operation discards in-flight words; no sample_valid until 3 cycles after the first post-reset angle_valid.
- Stage 1 (register on angle_valid):
  - q = angle[ANGLE_W-1:ANGLE_W-2].
  - i = angle[ANGLE_W-3:0].
  - Folded index k = i for q=0,2; k = QTR - i for q=1,3, where QTR = `QTR_WORDS = 1024.
  - Register neg = q[1].
- Stage 2: registered ROM read of entry k.
  - ROM holds QTR+1 = 1025 entries: round(32767*sin(pi*k/2048)), k=0..1024.
  - Entry 0 = 0; entry 1024 = 32767. Table is unsigned, OUT_W-1 bits.
- Stage 3: sample = neg ? -rom : +rom, sign-extended to OUT_W. Range -32767..+32767; -32768 never produced. sample_valid pulses.
- Latency: angle_valid at edge N -> sample_valid high after edge N+3.
- Throughput: one word per cycle. Back-to-back valids produce back-to-back outputs with no bubbles or stalls. There is no backpressure.
- Hold: with no valid, sample holds its last value and the pipeline registers do not toggle (clock-enabled by the valid chain).
- Wrap: phase 4095 -> 0 needs no special case; q and k fold naturally.
- Exact points:
  - 0 -> 0, 2048 -> 0.
  - 1024 -> +32767, 3072 -> -32767.
  - Negation of 0 yields 0.

Optional Feature:
- SINE_INTERP_EN defined:
  - angle is ANGLE_W+FRAC_W bits; the low FRAC_W bits are f.
  - ROM becomes dual read: reads k and k+1 for rising quadrants, k and k-1 for falling quadrants. Mirroring is applied per read so both stay within 0..1024.
  - Extra stage: v = a + (((b - a) * f) >>> FRAC_W), signed intermediate OUT_W+FRAC_W+1 bits, then sign restore.
  - Latency 4 cycles; throughput unchanged.
- Undefined: angle is ANGLE_W bits, single-port ROM, latency 3. The fractional path is absent from the netlist.

Decomposition:
- constants.v (shared) holds:
  - `SINE_WORDS and `QTR_WORDS.
  - `pac2sine_approx_t (width switched by SINE_INTERP_EN).
  - new `sine2out_t (signed [OUT_W-1:0]).
  - SINE_LATENCY (3 or 4).
- One sub-module: sine_qrom, the quarter-wave ROM with registered read, $readmemh(ROM_FILE) init, and a second read port under SINE_INTERP_EN. Quadrant folding and sign logic stay in sine_approx.

Test Plan:
- Single strobes at angle 0, 1024, 2048, 3072 -> samples 0, +32767, 0, -32767, each with sample_valid exactly 3 cycles after its strobe.
- angle 512 -> +23170; 1536 -> +23170; 2560 -> -23170; 3584 -> -23170. Checks mirror and sign symmetry.
- Sweep 0..4095 with angle_valid high every cycle -> 4096 consecutive valid outputs, each within ±1 LSB of round(32767*sin(2*pi*n/4096)); 4095 -> 0 wraps with no glitch.
- Sparse strobes, 1 per 100 cycles with a varying angle between strobes -> sample changes only on sample_valid and holds otherwise.
- Drop rst_n asynchronously with 3 words in flight -> sample = 0, sample_valid = 0 immediately; none of the 3 words emerges after release.
- SINE_INTERP_EN build, angle = (256<<4)|8 -> midpoint of ROM[256] and ROM[257] (±1 LSB), latency 4.
